multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_if.sv | 58 +++++
 rtl/multicycle_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl_if
// Description : Control bundle between the multicycle controller and its
//               datapath / shared memory.
//               master : the controller (drives all control strobes)
//               slave  : the datapath side (drives opcode, zero, mem_ready)
//   opcode    [6:0]  instruction register bits [6:0]
//   zero             ALU zero flag
//   mem_ready        shared memory completed the current access
//   mem_req          memory access request
//   mem_we           memory write enable
//   iord             memory address select: 0 = PC, 1 = ALU result
//   ir_we            instruction register load
//   pc_we            PC load
//   pc_src           PC source: 0 = PC+4, 1 = branch target register
//   reg_we           register file write
//   memtoreg         writeback source: 0 = ALU, 1 = memory data
//   alu_src_a        ALU A: 0 = PC, 1 = rs1
//   alu_src_b [1:0]  ALU B: 0 = rs2, 1 = constant 4, 2 = immediate
//   alu_op    [1:0]  00 = add, 01 = subtract, 10 = decode funct
//   retire           one-cycle pulse when an instruction completes
//   err       [1:0]  sticky errors: bit0 illegal opcode, bit1 memory timeout
//   state     [3:0]  current controller state, for debug
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_ctrl_if;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       iord;
  logic       ir_we;
  logic       pc_we;
  logic       pc_src;
  logic       reg_we;
  logic       memtoreg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       retire;
  logic [1:0] err;
  logic [3:0] state;

  modport master (
    input  opcode, zero, mem_ready,
    output mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_we, memtoreg,
           alu_src_a, alu_src_b, alu_op, retire, err, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_we, memtoreg,
           alu_src_a, alu_src_b, alu_op, retire, err, state
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Control FSM for a multicycle RISC-V style datapath sharing a
//               single memory between instruction fetch and load/store.
//               Memory states are bounded by a wait counter; a stalled access
//               is abandoned after MEM_TIMEOUT cycles and flagged in err[1].
// Ports       : clk   - single clock, rising edge
//               n_rst - asynchronous, active-high reset
//               bus   - multicycle_ctrl_if.master control bundle
// Parameters  : MEM_TIMEOUT - max cycles a memory state waits (2..255)
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input wire                 clk,
  input wire                 n_rst,
  multicycle_ctrl_if.master  bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_EXEC_I = 4'd3,
    S_ADDR   = 4'd4,
    S_BRANCH = 4'd5,
    S_MEM_RD = 4'd6,
    S_MEM_WR = 4'd7,
    S_WB_ALU = 4'd8,
    S_WB_MEM = 4'd9
  } state_t;

  // Control strobes that are a pure function of the state.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       pc_src;
    logic       reg_we;
    logic       memtoreg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } outs_t;

  localparam logic [6:0] c_op_r  = 7'b0110011;
  localparam logic [6:0] c_op_i  = 7'b0010011;
  localparam logic [6:0] c_op_ld = 7'b0000011;
  localparam logic [6:0] c_op_st = 7'b0100011;
  localparam logic [6:0] c_op_br = 7'b1100011;

  // Counter value seen in the last permitted waiting cycle.
  localparam logic [7:0] c_wait_last = 8'(MEM_TIMEOUT - 1);

  // FETCH strobes with the memory request held off, used while in reset.
  localparam outs_t c_reset_outs = '{
    mem_req:   1'b0,
    mem_we:    1'b0,
    iord:      1'b0,
    pc_src:    1'b0,
    reg_we:    1'b0,
    memtoreg:  1'b0,
    alu_src_a: 1'b0,
    alu_src_b: 2'd1,
    alu_op:    2'b00
  };

  function automatic outs_t f_decode(input state_t s);
    outs_t o;
    o = '0;
    case (s)
      S_FETCH: begin
        o.mem_req   = 1'b1;
        o.alu_src_b = 2'd1;
      end
      S_DECODE: begin
        o.alu_src_b = 2'd2;
      end
      S_EXEC_R: begin
        o.alu_src_a = 1'b1;
        o.alu_src_b = 2'd0;
        o.alu_op    = 2'b10;
      end
      S_EXEC_I: begin
        o.alu_src_a = 1'b1;
        o.alu_src_b = 2'd2;
        o.alu_op    = 2'b10;
      end
      S_ADDR: begin
        o.alu_src_a = 1'b1;
        o.alu_src_b = 2'd2;
      end
      S_BRANCH: begin
        o.alu_src_a = 1'b1;
        o.alu_src_b = 2'd0;
        o.alu_op    = 2'b01;
        o.pc_src    = 1'b1;
      end
      S_MEM_RD: begin
        o.mem_req = 1'b1;
        o.iord    = 1'b1;
      end
      S_MEM_WR: begin
        o.mem_req = 1'b1;
        o.mem_we  = 1'b1;
        o.iord    = 1'b1;
      end
      S_WB_ALU: begin
        o.reg_we = 1'b1;
      end
      S_WB_MEM: begin
        o.reg_we   = 1'b1;
        o.memtoreg = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

  state_t     r_state;
  outs_t      r_outs;
  logic [7:0] r_wait_cnt;
  logic [1:0] r_err;

  state_t     w_next_state;
  logic       w_ready;
  logic       w_waiting;
  logic       w_timeout;
  logic       w_illegal;
  logic       w_ir_we;
  logic       w_pc_we;
  logic       w_retire;

  // mem_ready only counts while a request is actually on the bus. The
  // request register is low for the first cycle after reset release, so
  // that cycle neither accepts data nor consumes wait budget.
  assign w_ready = r_outs.mem_req & bus.mem_ready;

  always_comb begin
    w_next_state = r_state;
    w_waiting    = 1'b0;
    w_timeout    = 1'b0;
    w_illegal    = 1'b0;
    w_ir_we      = 1'b0;
    w_pc_we      = 1'b0;
    w_retire     = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (w_ready) begin
          w_ir_we      = 1'b1;
          w_pc_we      = 1'b1;
          w_next_state = S_DECODE;
        end else if (r_outs.mem_req) begin
          w_waiting = 1'b1;
          // A timed-out fetch leaves the PC alone and simply retries.
          if (r_wait_cnt == c_wait_last) begin
            w_timeout = 1'b1;
          end
        end
      end
      S_DECODE: begin
        case (bus.opcode)
          c_op_r:           w_next_state = S_EXEC_R;
          c_op_i:           w_next_state = S_EXEC_I;
          c_op_ld, c_op_st: w_next_state = S_ADDR;
          c_op_br:          w_next_state = S_BRANCH;
          default: begin
            w_illegal    = 1'b1;
            w_retire     = 1'b1;
            w_next_state = S_FETCH;
          end
        endcase
      end
      S_EXEC_R, S_EXEC_I: begin
        w_next_state = S_WB_ALU;
      end
      S_ADDR: begin
        w_next_state = (bus.opcode == c_op_ld) ? S_MEM_RD : S_MEM_WR;
      end
      S_BRANCH: begin
        w_pc_we      = bus.zero;
        w_retire     = 1'b1;
        w_next_state = S_FETCH;
      end
      S_MEM_RD, S_MEM_WR: begin
        if (w_ready) begin
          if (r_state == S_MEM_RD) begin
            w_next_state = S_WB_MEM;
          end else begin
            w_retire     = 1'b1;
            w_next_state = S_FETCH;
          end
        end else begin
          w_waiting = 1'b1;
          // Abandoned data access: the instruction retires, no writeback.
          if (r_wait_cnt == c_wait_last) begin
            w_timeout    = 1'b1;
            w_retire     = 1'b1;
            w_next_state = S_FETCH;
          end
        end
      end
      S_WB_ALU, S_WB_MEM: begin
        w_retire     = 1'b1;
        w_next_state = S_FETCH;
      end
      default: begin
        w_next_state = S_FETCH;
      end
    endcase
  end

  // Strobes are registered from the next state so they are glitch-free and
  // aligned with the state register.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      r_state    <= S_FETCH;
      r_outs     <= c_reset_outs;
      r_wait_cnt <= '0;
      r_err      <= '0;
    end else begin
      r_state <= w_next_state;
      r_outs  <= f_decode(w_next_state);
      r_err   <= r_err | {w_timeout, w_illegal};
      // Every state change and every fetch retry starts a fresh wait window.
      if ((w_next_state != r_state) || w_timeout) begin
        r_wait_cnt <= '0;
      end else if (w_waiting) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end
    end
  end

  assign bus.mem_req   = r_outs.mem_req;
  assign bus.mem_we    = r_outs.mem_we;
  assign bus.iord      = r_outs.iord;
  assign bus.pc_src    = r_outs.pc_src;
  assign bus.reg_we    = r_outs.reg_we;
  assign bus.memtoreg  = r_outs.memtoreg;
  assign bus.alu_src_a = r_outs.alu_src_a;
  assign bus.alu_src_b = r_outs.alu_src_b;
  assign bus.alu_op    = r_outs.alu_op;
  assign bus.err       = r_err;
  assign bus.state     = r_state;

  // Input-dependent pulses are masked during reset so an aborted
  // instruction cannot load the PC or IR.
  assign bus.ir_we  = w_ir_we  & ~n_rst;
  assign bus.pc_we  = w_pc_we  & ~n_rst;
  assign bus.retire = w_retire & ~n_rst;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Self-checking bench for multicycle_ctrl. Each instruction is
//               expanded into an expected per-cycle trace (state, strobes,
//               pulses, sticky errors) from the instruction class, memory
//               latencies and the timeout rule; the DUT is then stepped
//               through that trace.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

  localparam int T = 16;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  logic clk   = 1'b0;
  logic n_rst = 1'b1;

  always #5 clk = ~clk;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.MEM_TIMEOUT(T)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         st;
    bit         mr;
    bit         z;
    logic [6:0] op;
    bit         ir;
    bit         pc;
    bit         ret;
    logic [1:0] er;
  } rec_t;

  rec_t       q[$];
  logic [1:0] m_err;

  // Strobes per state: {mem_req,mem_we,iord,pc_src,reg_we,memtoreg,a,b,op}
  function automatic logic [10:0] exp_outs(input int s);
    case (s)
      0:       return {7'b1000000, 2'd1, 2'b00};
      1:       return {7'b0000000, 2'd2, 2'b00};
      2:       return {7'b0000001, 2'd0, 2'b10};
      3:       return {7'b0000001, 2'd2, 2'b10};
      4:       return {7'b0000001, 2'd2, 2'b00};
      5:       return {7'b0001001, 2'd0, 2'b01};
      6:       return {7'b1010000, 2'd0, 2'b00};
      7:       return {7'b1110000, 2'd0, 2'b00};
      8:       return {7'b0000100, 2'd0, 2'b00};
      9:       return {7'b0000110, 2'd0, 2'b00};
      default: return 11'h7ff;
    endcase
  endfunction

  function automatic bit rb();
    return bit'($urandom % 2);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push(input int st, input bit mr, input bit z, input logic [6:0] op,
                      input bit ir, input bit pc, input bit ret);
    rec_t r;
    r.st = st; r.mr = mr; r.z = z; r.op = op;
    r.ir = ir; r.pc = pc; r.ret = ret; r.er = m_err;
    q.push_back(r);
  endtask

  // fd / md: cycles of mem_ready low before the fetch / data access answers.
  task automatic build(input logic [6:0] op, input bit z, input int fd, input int md);
    int zeros;
    int s;
    bit legal;
    zeros = fd;
    while (zeros >= T) begin
      repeat (T) push(0, 1'b0, rb(), op, 1'b0, 1'b0, 1'b0);
      m_err[1] = 1'b1;
      zeros -= T;
    end
    repeat (zeros) push(0, 1'b0, rb(), op, 1'b0, 1'b0, 1'b0);
    push(0, 1'b1, rb(), op, 1'b1, 1'b1, 1'b0);
    legal = (op == OP_R) || (op == OP_I) || (op == OP_LD) || (op == OP_ST) || (op == OP_BR);
    push(1, rb(), rb(), op, 1'b0, 1'b0, !legal);
    if (!legal) begin
      m_err[0] = 1'b1;
      return;
    end
    if (op == OP_R || op == OP_I) begin
      push((op == OP_R) ? 2 : 3, rb(), rb(), op, 1'b0, 1'b0, 1'b0);
      push(8, rb(), rb(), op, 1'b0, 1'b0, 1'b1);
    end else if (op == OP_BR) begin
      push(5, rb(), z, op, 1'b0, z, 1'b1);
    end else begin
      s = (op == OP_LD) ? 6 : 7;
      push(4, rb(), rb(), op, 1'b0, 1'b0, 1'b0);
      if (md >= T) begin
        repeat (T - 1) push(s, 1'b0, rb(), op, 1'b0, 1'b0, 1'b0);
        push(s, 1'b0, rb(), op, 1'b0, 1'b0, 1'b1);
        m_err[1] = 1'b1;
      end else begin
        repeat (md) push(s, 1'b0, rb(), op, 1'b0, 1'b0, 1'b0);
        if (op == OP_LD) begin
          push(6, 1'b1, rb(), op, 1'b0, 1'b0, 1'b0);
          push(9, rb(), rb(), op, 1'b0, 1'b0, 1'b1);
        end else begin
          push(7, 1'b1, rb(), op, 1'b0, 1'b0, 1'b1);
        end
      end
    end
  endtask

  task automatic run(input int limit);
    rec_t r;
    int   n;
    n = 0;
    while (q.size() > 0 && n < limit) begin
      r = q.pop_front();
      @(negedge clk);
      bus.mem_ready = r.mr;
      bus.zero      = r.z;
      bus.opcode    = r.op;
      #1;
      chk("state", 16'(bus.state), 16'(r.st));
      chk("ctrl", 16'({bus.mem_req, bus.mem_we, bus.iord, bus.pc_src, bus.reg_we,
                       bus.memtoreg, bus.alu_src_a, bus.alu_src_b, bus.alu_op}),
          16'(exp_outs(r.st)));
      chk("pulse", 16'({bus.ir_we, bus.pc_we, bus.retire}), 16'({r.ir, r.pc, r.ret}));
      chk("err", 16'(bus.err), 16'(r.er));
      n++;
    end
  endtask

  task automatic apply_reset();
    n_rst         = 1'b1;
    bus.mem_ready = 1'b1;
    bus.zero      = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("rst_state", 16'(bus.state), 16'd0);
      chk("rst_strobes", 16'({bus.mem_req, bus.mem_we, bus.reg_we}), 16'd0);
      chk("rst_pulse", 16'({bus.ir_we, bus.pc_we, bus.retire}), 16'd0);
      chk("rst_err", 16'(bus.err), 16'd0);
    end
    @(negedge clk);
    n_rst         = 1'b0;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    m_err = 2'b00;
    q.delete();
  endtask

  initial begin
    logic [6:0] op;
    int         k;
    int         fd;
    int         md;

    bus.opcode    = '0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    m_err         = 2'b00;

    apply_reset();

    // Directed: R-type, LW with 3 wait cycles, BEQ taken/not taken,
    // illegal opcode, SW timeout, fetch timeout with retry.
    build(OP_R, 1'b0, 0, 0);
    build(OP_LD, 1'b0, 0, 3);
    build(OP_BR, 1'b1, 0, 0);
    build(OP_BR, 1'b0, 0, 0);
    build(7'b1111111, 1'b0, 0, 0);
    build(OP_ST, 1'b0, 1, 20);
    build(OP_I, 1'b0, 17, 0);
    run(100000);

    // Random instruction mix.
    for (int i = 0; i < 40; i++) begin
      k = int'($urandom_range(0, 5));
      case (k)
        0: op = OP_R;
        1: op = OP_I;
        2: op = OP_LD;
        3: op = OP_ST;
        4: op = OP_BR;
        default: begin
          op = 7'($urandom);
          while (op == OP_R || op == OP_I || op == OP_LD || op == OP_ST || op == OP_BR)
            op = 7'($urandom);
        end
      endcase
      fd = ($urandom_range(0, 9) == 0) ? 17 : int'($urandom_range(0, 2));
      md = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 4));
      build(op, rb(), fd, md);
    end
    run(100000);

    // Reset in the middle of a store: FETCH, DECODE, ADDR, MEM_WR, MEM_WR.
    build(OP_ST, 1'b0, 0, 30);
    run(5);
    n_rst = 1'b1;
    #1;
    chk("async_state", 16'(bus.state), 16'd0);
    chk("async_mem", 16'({bus.mem_req, bus.mem_we}), 16'd0);
    chk("async_err", 16'(bus.err), 16'd0);
    apply_reset();

    // Recovery after reset.
    build(OP_R, 1'b0, 0, 0);
    build(OP_LD, 1'b0, 2, 1);
    run(100000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
